// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush and memory-stall freeze.
// Define PIPE_STATS_EN to add the saturating bubble_cnt statistics output.
module id_ex_pipe_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic        flush,
    input  logic        IF_ID_valid,
    input  logic [3:0]  IF_ID_RegRd1,
    input  logic [3:0]  IF_ID_RegRd2,
    input  logic [3:0]  IF_ID_RegWd,
    input  logic        IF_ID_uses_rd2,
    input  logic        IF_ID_RegWrite,
    input  logic        IF_ID_MemRead,
    input  logic        IF_ID_MemWrite,
    input  logic        IF_ID_ALUsrc,
    input  logic [3:0]  IF_ID_ALUop,
    input  logic [15:0] IF_ID_Rd1Data,
    input  logic [15:0] IF_ID_Rd2Data,
    input  logic [15:0] IF_ID_Imm,
    output logic        ID_EX_valid,
    output logic        ID_EX_RegWrite,
    output logic        ID_EX_MemRead,
    output logic        ID_EX_MemWrite,
    output logic        ID_EX_ALUsrc,
    output logic [3:0]  ID_EX_RegRd1,
    output logic [3:0]  ID_EX_RegRd2,
    output logic [3:0]  ID_EX_RegWd,
    output logic [3:0]  ID_EX_ALUop,
    output logic [15:0] ID_EX_Rd1Data,
    output logic [15:0] ID_EX_Rd2Data,
    output logic [15:0] ID_EX_Imm,
`ifdef PIPE_STATS_EN
    output logic        stall_fd,
    output logic [15:0] bubble_cnt
`else
    output logic        stall_fd
`endif
);

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        aluSrc;
        logic [3:0]  regRd1;
        logic [3:0]  regRd2;
        logic [3:0]  regWd;
        logic [3:0]  aluOp;
        logic [15:0] rd1Data;
        logic [15:0] rd2Data;
        logic [15:0] imm;
    } stageT;

    stageT decodeIn;
    stageT idExQ;
    logic  loadUse;
    logic  insertBubble;

    assign decodeIn = '{
        valid:    IF_ID_valid,
        regWrite: IF_ID_RegWrite,
        memRead:  IF_ID_MemRead,
        memWrite: IF_ID_MemWrite,
        aluSrc:   IF_ID_ALUsrc,
        regRd1:   IF_ID_RegRd1,
        regRd2:   IF_ID_RegRd2,
        regWd:    IF_ID_RegWd,
        aluOp:    IF_ID_ALUop,
        rd1Data:  IF_ID_Rd1Data,
        rd2Data:  IF_ID_Rd2Data,
        imm:      IF_ID_Imm
    };

    // Store data (RegRd2 of a store) is exempt: the MEM stage forwards load->store data.
    always_comb begin
        loadUse = IF_ID_valid & idExQ.valid & idExQ.memRead &
                  ((idExQ.regWd == IF_ID_RegRd1) |
                   (IF_ID_uses_rd2 & ~IF_ID_MemWrite & (idExQ.regWd == IF_ID_RegRd2)));
        insertBubble = flush | loadUse;
        stall_fd     = loadUse & ~flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idExQ <= '0;
        end else if (!mem_stall) begin
            if (insertBubble) begin
                idExQ <= '0;
            end else begin
                idExQ <= decodeIn;
            end
        end
    end

`ifdef PIPE_STATS_EN
    logic [15:0] bubbleCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubbleCnt <= '0;
        end else if (!mem_stall && insertBubble && (bubbleCnt != '1)) begin
            bubbleCnt <= bubbleCnt + 16'd1;
        end
    end

    assign bubble_cnt = bubbleCnt;
`endif

    assign ID_EX_valid    = idExQ.valid;
    assign ID_EX_RegWrite = idExQ.regWrite;
    assign ID_EX_MemRead  = idExQ.memRead;
    assign ID_EX_MemWrite = idExQ.memWrite;
    assign ID_EX_ALUsrc   = idExQ.aluSrc;
    assign ID_EX_RegRd1   = idExQ.regRd1;
    assign ID_EX_RegRd2   = idExQ.regRd2;
    assign ID_EX_RegWd    = idExQ.regWd;
    assign ID_EX_ALUop    = idExQ.aluOp;
    assign ID_EX_Rd1Data  = idExQ.rd1Data;
    assign ID_EX_Rd2Data  = idExQ.rd2Data;
    assign ID_EX_Imm      = idExQ.imm;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed hazard scenarios plus randomized traffic
// against a record-level reference model. Build with PIPE_STATS_EN to also check bubble_cnt.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        aluSrc;
        logic [3:0]  regRd1;
        logic [3:0]  regRd2;
        logic [3:0]  regWd;
        logic [3:0]  aluOp;
        logic [15:0] rd1Data;
        logic [15:0] rd2Data;
        logic [15:0] imm;
    } instrT;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  memStall = 1'b0;
    logic  flush = 1'b0;
    logic  usesRd2 = 1'b0;
    instrT dec = '0;
    instrT obs;
    logic  stallFd;
`ifdef PIPE_STATS_EN
    logic [15:0] bubbleCnt;
    int unsigned modelCnt = 0;
`endif

    instrT       model = '0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk            (clk),
        .rst            (rst),
        .mem_stall      (memStall),
        .flush          (flush),
        .IF_ID_valid    (dec.valid),
        .IF_ID_RegRd1   (dec.regRd1),
        .IF_ID_RegRd2   (dec.regRd2),
        .IF_ID_RegWd    (dec.regWd),
        .IF_ID_uses_rd2 (usesRd2),
        .IF_ID_RegWrite (dec.regWrite),
        .IF_ID_MemRead  (dec.memRead),
        .IF_ID_MemWrite (dec.memWrite),
        .IF_ID_ALUsrc   (dec.aluSrc),
        .IF_ID_ALUop    (dec.aluOp),
        .IF_ID_Rd1Data  (dec.rd1Data),
        .IF_ID_Rd2Data  (dec.rd2Data),
        .IF_ID_Imm      (dec.imm),
        .ID_EX_valid    (obs.valid),
        .ID_EX_RegWrite (obs.regWrite),
        .ID_EX_MemRead  (obs.memRead),
        .ID_EX_MemWrite (obs.memWrite),
        .ID_EX_ALUsrc   (obs.aluSrc),
        .ID_EX_RegRd1   (obs.regRd1),
        .ID_EX_RegRd2   (obs.regRd2),
        .ID_EX_RegWd    (obs.regWd),
        .ID_EX_ALUop    (obs.aluOp),
        .ID_EX_Rd1Data  (obs.rd1Data),
        .ID_EX_Rd2Data  (obs.rd2Data),
        .ID_EX_Imm      (obs.imm),
`ifdef PIPE_STATS_EN
        .stall_fd       (stallFd),
        .bubble_cnt     (bubbleCnt)
`else
        .stall_fd       (stallFd)
`endif
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A load sitting in EX blocks any decoded instruction that reads its result,
    // except when the only match is a store's data operand.
    function automatic bit hazard();
        bit readsRd1;
        bit readsRd2;
        readsRd1 = (model.regWd == dec.regRd1);
        readsRd2 = usesRd2 && !dec.memWrite && (model.regWd == dec.regRd2);
        return dec.valid && model.valid && model.memRead && (readsRd1 || readsRd2);
    endfunction

    function automatic bit expStall();
        return hazard() && !flush;
    endfunction

    task automatic modelEdge();
        bit bubble;
        bubble = flush || hazard();
        if (!memStall) begin
            model = bubble ? instrT'('0) : dec;
`ifdef PIPE_STATS_EN
            if (bubble && modelCnt < 65535) modelCnt++;
`endif
        end
    endtask

    task automatic modelReset();
        model = '0;
`ifdef PIPE_STATS_EN
        modelCnt = 0;
`endif
    endtask

    task automatic checkOutputs(input string tag);
        check({tag, " outputs"}, 80'(obs), 80'(model));
`ifdef PIPE_STATS_EN
        check({tag, " bubble_cnt"}, 80'(bubbleCnt), 80'(modelCnt));
`endif
    endtask

    // Called just after a negedge once inputs are driven; returns at the next negedge.
    task automatic cycle(input string tag);
        #1;
        check({tag, " stall_fd"}, 80'(stallFd), 80'(expStall()));
        @(posedge clk);
        modelEdge();
        #1;
        checkOutputs(tag);
        @(negedge clk);
    endtask

    function automatic instrT mkInstr(input logic [3:0] rd1, input logic [3:0] rd2,
                                      input logic [3:0] wd, input logic memRd, input logic memWr);
        instrT r;
        r          = '0;
        r.valid    = 1'b1;
        r.regWrite = !memWr;
        r.memRead  = memRd;
        r.memWrite = memWr;
        r.aluSrc   = memRd || memWr;
        r.regRd1   = rd1;
        r.regRd2   = rd2;
        r.regWd    = wd;
        r.aluOp    = 4'h2;
        r.rd1Data  = 16'(wd) * 16'h0101;
        r.rd2Data  = 16'hBEEF;
        r.imm      = 16'h0010;
        return r;
    endfunction

    task automatic randomDecode();
        dec.valid    = ($urandom_range(0, 7) != 0);
        dec.regWrite = 1'($urandom);
        dec.memRead  = ($urandom_range(0, 2) == 0);
        dec.memWrite = ($urandom_range(0, 3) == 0);
        dec.aluSrc   = 1'($urandom);
        dec.regRd1   = 4'($urandom_range(0, 3));
        dec.regRd2   = 4'($urandom_range(0, 3));
        dec.regWd    = 4'($urandom_range(0, 3));
        dec.aluOp    = 4'($urandom);
        dec.rd1Data  = 16'($urandom);
        dec.rd2Data  = 16'($urandom);
        dec.imm      = 16'($urandom);
        usesRd2      = 1'($urandom);
    endtask

    initial begin
        #12;
        check("reset outputs", 80'(obs), 80'(0));
        check("reset stall_fd", 80'(stallFd), 80'(0));
`ifdef PIPE_STATS_EN
        check("reset bubble_cnt", 80'(bubbleCnt), 80'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        modelReset();

        // V1: load r3 then an add reading r3 -> one bubble, then the add.
        dec = mkInstr(4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
        cycle("V1 load");
        dec = mkInstr(4'd3, 4'd4, 4'd6, 1'b0, 1'b0);
        usesRd2 = 1'b1;
        #1 check("V1 stall_fd", 80'(stallFd), 80'(1));
        cycle("V1 bubble");
        check("V1 bubble valid", 80'(obs.valid), 80'(0));
        cycle("V1 add");
        check("V1 add valid", 80'(obs.valid), 80'(1));
        check("V1 add RegRd1", 80'(obs.regRd1), 80'(3));

        // V2: store data operand matches load destination -> no stall.
        dec = mkInstr(4'd1, 4'd2, 4'd5, 1'b1, 1'b0);
        usesRd2 = 1'b0;
        cycle("V2 load");
        dec = mkInstr(4'd7, 4'd5, 4'd0, 1'b0, 1'b1);
        usesRd2 = 1'b1;
        #1 check("V2 stall_fd", 80'(stallFd), 80'(0));
        cycle("V2 store");
        check("V2 store MemWrite", 80'(obs.memWrite), 80'(1));
        check("V2 store RegRd2", 80'(obs.regRd2), 80'(5));

        // V3: flush coincides with a load-use hazard.
        dec = mkInstr(4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
        usesRd2 = 1'b0;
        cycle("V3 load");
        dec = mkInstr(4'd3, 4'd3, 4'd8, 1'b0, 1'b0);
        flush = 1'b1;
        #1 check("V3 stall_fd", 80'(stallFd), 80'(0));
        cycle("V3 flush");
        check("V3 valid", 80'(obs.valid), 80'(0));
        flush = 1'b0;

        // V4: mem_stall freezes the stage while decode inputs keep changing.
        dec = mkInstr(4'd9, 4'd10, 4'd11, 1'b0, 1'b0);
        dec.rd1Data = 16'h1234;
        cycle("V4 capture");
        memStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomDecode();
            cycle("V4 hold");
            check("V4 Rd1Data", 80'(obs.rd1Data), 80'(16'h1234));
            check("V4 valid", 80'(obs.valid), 80'(1));
        end
        memStall = 1'b0;

        // V5: asynchronous reset pulse between edges.
        dec = mkInstr(4'd12, 4'd13, 4'd14, 1'b1, 1'b0);
        cycle("V5 capture");
        #2 rst = 1'b1;
        #1;
        modelReset();
        check("V5 async outputs", 80'(obs), 80'(0));
        check("V5 stall_fd", 80'(stallFd), 80'(0));
        #1 rst = 1'b0;
        dec = mkInstr(4'd12, 4'd13, 4'd2, 1'b0, 1'b0);
        cycle("V5 post-reset");
        check("V5 post valid", 80'(obs.valid), 80'(1));

`ifdef PIPE_STATS_EN
        // V6: counter saturates at all-ones.
        force dut.bubbleCnt = 16'hFFFE;
        #1 release dut.bubbleCnt;
        modelCnt = 65534;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("V6 saturate");
            check("V6 bubble_cnt", 80'(bubbleCnt), 80'(i == 0 ? 16'hFFFF : 16'hFFFF));
        end
        flush = 1'b0;
        rst = 1'b1;
        #1 modelReset();
        rst = 1'b0;
`endif

        // Randomized traffic with small register numbers to provoke hazards often.
        for (int n = 0; n < 400; n++) begin
            randomDecode();
            flush    = ($urandom_range(0, 9) == 0);
            memStall = ($urandom_range(0, 6) == 0);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have ports, clock and reset first; one clock, reset asynchronous active-high:
 clk  in  1  pipeline clock, rising edge
 rst  in  1  asynchronous active-high reset
 mem_stall  in  1  cache busy; freeze whole stage
 flush  in  1  branch/jump taken; squash decode instruction
 IF_ID_valid  in  1  decode slot holds a real instruction
 IF_ID_RegRd1, IF_ID_RegRd2, IF_ID_RegWd  in  4 each  source/dest register numbers
 IF_ID_uses_rd2  in  1  instruction reads RegRd2
 IF_ID_RegWrite, IF_ID_MemRead, IF_ID_MemWrite, IF_ID_ALUsrc  in  1 each  decode controls
 IF_ID_ALUop  in  4  ALU operation
 IF_ID_Rd1Data, IF_ID_Rd2Data, IF_ID_Imm  in  16 each  operand data, immediate
 ID_EX_valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUsrc  out  1 each  registered controls
 ID_EX_RegRd1, ID_EX_RegRd2, ID_EX_RegWd  out  4 each  registered register numbers, consumed by forwarding unit
 ID_EX_ALUop  out  4;  ID_EX_Rd1Data, ID_EX_Rd2Data, ID_EX_Imm  out  16 each
 stall_fd  out  1  combinational: hold PC and IF/ID this cycle
 bubble_cnt  out  16  bubble statistics (present only with PIPE_STATS_EN)

Function
REQ-002 SHALL define load_use = IF_ID_valid & ID_EX_valid & ID_EX_MemRead & (ID_EX_RegWd==IF_ID_RegRd1 | (IF_ID_uses_rd2 & ~IF_ID_MemWrite & ID_EX_RegWd==IF_ID_RegRd2)).
REQ-003 SHALL exempt store-data RegRd2 from load_use; MEM-stage forwarding covers load->store data.
REQ-004 SHALL drive stall_fd = load_use & ~flush, combinationally, in the same cycle.
REQ-005 Per rising edge, first match wins: mem_stall -> all outputs hold; flush -> bubble; load_use -> bubble; else capture all IF_ID_* into ID_EX_* (valid <= IF_ID_valid).
REQ-006 Bubble SHALL set ID_EX_valid, RegWrite, MemRead, MemWrite, ALUsrc to 0 and all other ID_EX_* fields to 0.
REQ-007 SHALL keep stall_fd driven per REQ-004 during mem_stall; upstream freezes either way.
REQ-008 Latency SHALL be one cycle decode->ID_EX outputs; a load-use pair SHALL cost exactly one bubble, after which ID_EX_MemRead=0 clears load_use.
REQ-009 Register number 0 SHALL NOT be special-cased in hazard comparison.
REQ-010 Simultaneous flush and load_use SHALL produce one bubble, stall_fd=0.

Reset
REQ-011 rst SHALL asynchronously clear every ID_EX_* output and bubble_cnt to 0; stall_fd then follows REQ-004 (0, as ID_EX_valid=0).
REQ-012 rst asserted mid-stall or mid-bubble SHALL override all; first post-reset edge captures decode normally.

Configuration
REQ-013 With PIPE_STATS_EN defined, bubble_cnt SHALL increment by 1 on every edge that inserts a bubble (flush or load_use, not mem_stall), saturating at 16'hFFFF.
REQ-014 Without PIPE_STATS_EN, port bubble_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-015 Bench SHALL cover:
 V1: ID_EX load RegWd=3, decode add RegRd1=3 -> stall_fd=1 same cycle; next edge ID_EX_valid=0; next edge add captured, RegRd1=3.
 V2: ID_EX load RegWd=5, decode store RegRd2=5 uses_rd2=1 MemWrite=1 -> stall_fd=0, store captured next edge.
 V3: load_use and flush same cycle -> stall_fd=0, one bubble, bubble_cnt +1 (PIPE_STATS_EN).
 V4: mem_stall=1 for 3 cycles with Rd1Data=16'h1234 changing inputs -> outputs hold prior values all 3 cycles.
 V5: rst pulsed mid-clock while ID_EX_valid=1 -> all outputs 0 immediately, before next edge.
 V6: force bubble_cnt to 16'hFFFE, 3 bubbles -> 16'hFFFF, stays 16'hFFFF.
